// File: rtl/yscaler_ctl.sv
// -----------------------------------------------------------------------------
// yscaler_ctl
//
// Frame-level sequencer for the yscaler datapath.
//   * Holds the software resolution configuration in shadow registers.
//   * Commits the shadow into the active (scaler-facing) registers only when a
//     frame starts.
//   * Issues a one-cycle fsync pulse to the scaler.
//   * Monitors the scaler m_axis output to detect frame completion,
//     protocol errors and stalls.
//
// Ports
//   clk, resetn            rising-edge clock, asynchronous active-low reset
//   enable                 run request, sampled when a frame starts
//   cfg_wr, cfg_*          one-cycle strobe that loads the shadow config
//   src_fsync              upstream frame-start pulse
//   err_clr                clears every sticky error flag
//   s_/m_width/height      active resolution driven to the scaler
//   fsync                  one-cycle scaler reset pulse (high only in SYNC)
//   mon_t*                 passive taps on the scaler m_axis interface
//   busy                   high in LOAD, SYNC and RUN
//   frame_done             one-cycle pulse on the last beat of a frame
//   frame_cnt              completed-frame counter, wraps to 0
//   err_cfg/sof/line/ovr/tmo  sticky error flags
// -----------------------------------------------------------------------------
module yscaler_ctl #(
    parameter int C_RESO_WIDTH    = 10,
    parameter int C_TIMEOUT_WIDTH = 20,
    parameter int C_FCNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    cfg_wr,
    input  logic [C_RESO_WIDTH-1:0] cfg_s_width,
    input  logic [C_RESO_WIDTH-1:0] cfg_s_height,
    input  logic [C_RESO_WIDTH-1:0] cfg_m_width,
    input  logic [C_RESO_WIDTH-1:0] cfg_m_height,
    input  logic                    src_fsync,
    input  logic                    err_clr,
    output logic [C_RESO_WIDTH-1:0] s_width,
    output logic [C_RESO_WIDTH-1:0] s_height,
    output logic [C_RESO_WIDTH-1:0] m_width,
    output logic [C_RESO_WIDTH-1:0] m_height,
    output logic                    fsync,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    input  logic                    mon_tuser,
    input  logic                    mon_tlast,
    output logic                    busy,
    output logic                    frame_done,
    output logic [C_FCNT_WIDTH-1:0] frame_cnt,
    output logic                    err_cfg,
    output logic                    err_sof,
    output logic                    err_line,
    output logic                    err_ovr,
    output logic                    err_tmo
);

    localparam int RW = C_RESO_WIDTH;
    localparam int TW = C_TIMEOUT_WIDTH;
    localparam int FW = C_FCNT_WIDTH;

    localparam logic [RW-1:0] RESO_ONE  = RW'(1);
    localparam logic [TW-1:0] STALL_ONE = TW'(1);
    localparam logic [FW-1:0] FCNT_ONE  = FW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SYNC = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Shadow configuration (software side)
    logic [RW-1:0] shd_sw_q, shd_sw_d;
    logic [RW-1:0] shd_sh_q, shd_sh_d;
    logic [RW-1:0] shd_mw_q, shd_mw_d;
    logic [RW-1:0] shd_mh_q, shd_mh_d;
    logic          shd_vld_q, shd_vld_d;

    // Active configuration (scaler side)
    logic [RW-1:0] act_sw_q, act_sw_d;
    logic [RW-1:0] act_sh_q, act_sh_d;
    logic [RW-1:0] act_mw_q, act_mw_d;
    logic [RW-1:0] act_mh_q, act_mh_d;

    // Frame monitor state
    logic [RW-1:0] pix_q, pix_d;
    logic [RW-1:0] line_q, line_d;
    logic [TW-1:0] stall_q, stall_d;
    logic          first_q, first_d;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Sticky errors
    logic err_cfg_q, err_cfg_d;
    logic err_sof_q, err_sof_d;
    logic err_line_q, err_line_d;
    logic err_ovr_q, err_ovr_d;
    logic err_tmo_q, err_tmo_d;

    logic in_run;
    logic beat;
    logic run_beat;
    logic pix_last;
    logic line_last;
    logic stall_full;
    logic done;
    logic tmo;
    logic cfg_zero;
    logic cfg_bad;
    logic cfg_ok;
    logic can_start;
    logic load_act;

    assign in_run     = (state_q == ST_RUN);
    assign beat       = mon_tvalid & mon_tready;
    assign run_beat   = in_run & beat;
    // Fields are never zero once active, so the -1 cannot underflow.
    assign pix_last   = (pix_q == (act_mw_q - RESO_ONE));
    assign line_last  = (line_q == (act_mh_q - RESO_ONE));
    assign stall_full = &stall_q;
    // Frame completion is combinational on the registered counters so it
    // lands in the same cycle as the final beat.
    assign done       = run_beat & mon_tlast & line_last;
    // A src_fsync in the same cycle takes priority over the timeout.
    assign tmo        = in_run & ~src_fsync & ~beat & stall_full;
    assign cfg_zero   = (cfg_s_width  == '0) | (cfg_s_height == '0) |
                        (cfg_m_width  == '0) | (cfg_m_height == '0);
    assign cfg_bad    = cfg_wr & cfg_zero;
    assign cfg_ok     = cfg_wr & ~cfg_zero;
    assign can_start  = enable & shd_vld_q;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d  = state_q;
        load_act = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (src_fsync && can_start) begin
                    state_d  = ST_LOAD;
                    load_act = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (src_fsync) begin
                    // Overrun: abandon the frame and restart if allowed.
                    if (can_start) begin
                        state_d  = ST_LOAD;
                        load_act = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (done) begin
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    // Re-sync the scaler with the unchanged active config.
                    state_d = ST_SYNC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- shadow
    always_comb begin
        shd_sw_d  = shd_sw_q;
        shd_sh_d  = shd_sh_q;
        shd_mw_d  = shd_mw_q;
        shd_mh_d  = shd_mh_q;
        shd_vld_d = shd_vld_q;
        if (cfg_ok) begin
            shd_sw_d  = cfg_s_width;
            shd_sh_d  = cfg_s_height;
            shd_mw_d  = cfg_m_width;
            shd_mh_d  = cfg_m_height;
            shd_vld_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- active
    // Copied on the transition into LOAD so the scaler sees the new
    // resolution for a full cycle before the fsync pulse in SYNC.
    always_comb begin
        act_sw_d = act_sw_q;
        act_sh_d = act_sh_q;
        act_mw_d = act_mw_q;
        act_mh_d = act_mh_q;
        if (load_act) begin
            act_sw_d = shd_sw_q;
            act_sh_d = shd_sh_q;
            act_mw_d = shd_mw_q;
            act_mh_d = shd_mh_q;
        end
    end

    // ---------------------------------------------------------------- monitor
    always_comb begin
        pix_d   = pix_q;
        line_d  = line_q;
        stall_d = stall_q;
        first_d = first_q;
        fcnt_d  = fcnt_q;
        if (!in_run || (state_d != ST_RUN)) begin
            // Every entry into RUN starts from clean counters.
            pix_d   = '0;
            line_d  = '0;
            stall_d = '0;
            first_d = 1'b1;
        end else if (beat) begin
            stall_d = '0;
            first_d = 1'b0;
            // Counters follow tlast even when its position is wrong.
            if (mon_tlast) begin
                pix_d  = '0;
                line_d = line_q + RESO_ONE;
            end else begin
                pix_d = pix_q + RESO_ONE;
            end
        end else begin
            stall_d = stall_q + STALL_ONE;
        end
        if (done) begin
            fcnt_d = fcnt_q + FCNT_ONE;
        end
    end

    // ---------------------------------------------------------------- errors
    // A set in the same cycle as err_clr wins.
    always_comb begin
        err_cfg_d  = cfg_bad                           | (err_cfg_q  & ~err_clr);
        err_sof_d  = (run_beat & first_q & ~mon_tuser) | (err_sof_q  & ~err_clr);
        err_line_d = (run_beat & (mon_tlast ^ pix_last)) | (err_line_q & ~err_clr);
        err_ovr_d  = (in_run & src_fsync)              | (err_ovr_q  & ~err_clr);
        err_tmo_d  = tmo                               | (err_tmo_q  & ~err_clr);
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shd_sw_q   <= '0;
            shd_sh_q   <= '0;
            shd_mw_q   <= '0;
            shd_mh_q   <= '0;
            shd_vld_q  <= 1'b0;
            act_sw_q   <= '0;
            act_sh_q   <= '0;
            act_mw_q   <= '0;
            act_mh_q   <= '0;
            pix_q      <= '0;
            line_q     <= '0;
            stall_q    <= '0;
            first_q    <= 1'b1;
            fcnt_q     <= '0;
            err_cfg_q  <= 1'b0;
            err_sof_q  <= 1'b0;
            err_line_q <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shd_sw_q   <= shd_sw_d;
            shd_sh_q   <= shd_sh_d;
            shd_mw_q   <= shd_mw_d;
            shd_mh_q   <= shd_mh_d;
            shd_vld_q  <= shd_vld_d;
            act_sw_q   <= act_sw_d;
            act_sh_q   <= act_sh_d;
            act_mw_q   <= act_mw_d;
            act_mh_q   <= act_mh_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            stall_q    <= stall_d;
            first_q    <= first_d;
            fcnt_q     <= fcnt_d;
            err_cfg_q  <= err_cfg_d;
            err_sof_q  <= err_sof_d;
            err_line_q <= err_line_d;
            err_ovr_q  <= err_ovr_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign s_width    = act_sw_q;
    assign s_height   = act_sh_q;
    assign m_width    = act_mw_q;
    assign m_height   = act_mh_q;
    assign fsync      = (state_q == ST_SYNC);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done;
    assign frame_cnt  = fcnt_q;
    assign err_cfg    = err_cfg_q;
    assign err_sof    = err_sof_q;
    assign err_line   = err_line_q;
    assign err_ovr    = err_ovr_q;
    assign err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_yscaler_ctl.sv
// -----------------------------------------------------------------------------
// tb_yscaler_ctl
//
// Directed table of per-cycle vectors, hand-written multi-cycle sequences
// (stall timeout, config change mid-frame, asynchronous reset) and a long
// randomized run checked against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_yscaler_ctl;

    localparam int RW  = 10;
    localparam int TW  = 4;
    localparam int FW  = 16;
    localparam int TMO = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          cfg_wr;
    logic [RW-1:0] cfg_s_width, cfg_s_height, cfg_m_width, cfg_m_height;
    logic          src_fsync;
    logic          err_clr;
    logic [RW-1:0] s_width, s_height, m_width, m_height;
    logic          fsync;
    logic          mon_tvalid, mon_tready, mon_tuser, mon_tlast;
    logic          busy, frame_done;
    logic [FW-1:0] frame_cnt;
    logic          err_cfg, err_sof, err_line, err_ovr, err_tmo;

    yscaler_ctl #(
        .C_RESO_WIDTH    (RW),
        .C_TIMEOUT_WIDTH (TW),
        .C_FCNT_WIDTH    (FW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .cfg_wr       (cfg_wr),
        .cfg_s_width  (cfg_s_width),
        .cfg_s_height (cfg_s_height),
        .cfg_m_width  (cfg_m_width),
        .cfg_m_height (cfg_m_height),
        .src_fsync    (src_fsync),
        .err_clr      (err_clr),
        .s_width      (s_width),
        .s_height     (s_height),
        .m_width      (m_width),
        .m_height     (m_height),
        .fsync        (fsync),
        .mon_tvalid   (mon_tvalid),
        .mon_tready   (mon_tready),
        .mon_tuser    (mon_tuser),
        .mon_tlast    (mon_tlast),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .err_cfg      (err_cfg),
        .err_sof      (err_sof),
        .err_line     (err_line),
        .err_ovr      (err_ovr),
        .err_tmo      (err_tmo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_all();
        return {busy, fsync, frame_done, frame_cnt, s_width, s_height, m_width, m_height,
                err_cfg, err_sof, err_line, err_ovr, err_tmo};
    endfunction

    function automatic logic [63:0] dut_tab();
        return 64'({busy, fsync, frame_done, frame_cnt, m_width,
                    err_cfg, err_sof, err_line, err_ovr, err_tmo});
    endfunction

    task automatic clr_in();
        cfg_wr     = 1'b0;
        src_fsync  = 1'b0;
        err_clr    = 1'b0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tuser  = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_cfg(input int sw, input int sh, input int mw, input int mh);
        cfg_wr       = 1'b1;
        cfg_s_width  = RW'(sw);
        cfg_s_height = RW'(sh);
        cfg_m_width  = RW'(mw);
        cfg_m_height = RW'(mh);
    endtask

    task automatic beat(input bit tu, input bit tl);
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tuser  = tu;
        mon_tlast  = tl;
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        bit       wr;
        int       sw, sh, mw, mh;
        bit       fs, tv, tu, tl, clr;
        bit       eb, ef, ed;
        int       ec, emw;
        bit [4:0] ee;
    } vec_t;

    function automatic vec_t mk(input bit wr, input int sw, input int sh, input int mw,
                                input int mh, input bit fs, input bit tv, input bit tu,
                                input bit tl, input bit clr, input bit eb, input bit ef,
                                input bit ed, input int ec, input int emw, input bit [4:0] ee);
        vec_t v;
        v.wr = wr; v.sw = sw; v.sh = sh; v.mw = mw; v.mh = mh;
        v.fs = fs; v.tv = tv; v.tu = tu; v.tl = tl; v.clr = clr;
        v.eb = eb; v.ef = ef; v.ed = ed; v.ec = ec; v.emw = emw; v.ee = ee;
        return v;
    endfunction

    // ---------------------------------------------------------------- model
    int       md_wait;
    bit       md_run;
    int       md_sh[4];
    bit       md_sv;
    int       md_act[4];
    int       md_lines, md_bil, md_idle;
    bit       md_seen;
    int       md_fcnt;
    bit [4:0] md_err;

    task automatic model_reset();
        md_wait = 0; md_run = 0; md_sv = 0;
        for (int i = 0; i < 4; i++) begin
            md_sh[i]  = 0;
            md_act[i] = 0;
        end
        md_lines = 0; md_bil = 0; md_idle = 0; md_seen = 0;
        md_fcnt = 0; md_err = '0;
    endtask

    function automatic bit model_fin();
        return md_run && mon_tvalid && mon_tready && mon_tlast && (md_lines == md_act[3] - 1);
    endfunction

    function automatic logic [63:0] model_expect();
        bit b_busy, b_fs;
        b_busy = md_run || (md_wait > 0);
        b_fs   = (md_wait == 1);
        return {b_busy, b_fs, model_fin(), FW'(md_fcnt),
                RW'(md_act[0]), RW'(md_act[1]), RW'(md_act[2]), RW'(md_act[3]), md_err};
    endfunction

    task automatic model_step();
        bit       bt, fin, tmo, bad, start_ok;
        bit [4:0] sets;
        bt       = mon_tvalid && mon_tready;
        fin      = model_fin();
        tmo      = md_run && !src_fsync && !bt && (md_idle == TMO);
        start_ok = enable && md_sv;
        bad      = cfg_wr && (cfg_s_width == 0 || cfg_s_height == 0 ||
                              cfg_m_width == 0 || cfg_m_height == 0);
        sets     = '0;
        if (bad) sets[4] = 1'b1;
        if (md_run && bt && !md_seen && !mon_tuser) sets[3] = 1'b1;
        if (md_run && bt && (mon_tlast != (md_bil == md_act[2] - 1))) sets[2] = 1'b1;
        if (md_run && src_fsync) sets[1] = 1'b1;
        if (tmo) sets[0] = 1'b1;
        md_err = sets | (md_err & {5{!err_clr}});
        if (fin) md_fcnt++;
        if (md_wait > 0) begin
            md_wait--;
            if (md_wait == 0) begin
                md_run = 1; md_lines = 0; md_bil = 0; md_idle = 0; md_seen = 0;
            end
        end else if (md_run) begin
            if (src_fsync) begin
                md_run = 0;
                if (start_ok) begin md_act = md_sh; md_wait = 2; end
            end else if (fin) begin
                md_run = 0;
            end else if (tmo) begin
                md_run = 0; md_wait = 1;
            end else if (bt) begin
                md_seen = 1; md_idle = 0;
                if (mon_tlast) begin md_lines++; md_bil = 0; end
                else md_bil++;
            end else begin
                md_idle++;
            end
        end else if (src_fsync && start_ok) begin
            md_act = md_sh; md_wait = 2;
        end
        if (cfg_wr && !bad) begin
            md_sh[0] = int'(cfg_s_width);  md_sh[1] = int'(cfg_s_height);
            md_sh[2] = int'(cfg_m_width);  md_sh[3] = int'(cfg_m_height);
            md_sv = 1;
        end
    endtask

    // ---------------------------------------------------------------- test
    vec_t tab[30];

    initial begin
        int early;
        int donecnt;
        int mwbad;
        int stall_left;

        tab[0]  = mk(1, 8, 4, 4, 2,  0,0,0,0,0,  0,0,0,0,0,5'b00000);
        tab[1]  = mk(0, 0, 0, 0, 0,  1,0,0,0,0,  0,0,0,0,0,5'b00000);
        tab[2]  = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,0,0,0,4,5'b00000);
        tab[3]  = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,1,0,0,4,5'b00000);
        tab[4]  = mk(0, 0, 0, 0, 0,  0,1,1,0,0,  1,0,0,0,4,5'b00000);
        tab[5]  = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,0,4,5'b00000);
        tab[6]  = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,0,4,5'b00000);
        tab[7]  = mk(0, 0, 0, 0, 0,  0,1,0,1,0,  1,0,0,0,4,5'b00000);
        tab[8]  = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,0,4,5'b00000);
        tab[9]  = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,0,4,5'b00000);
        tab[10] = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,0,4,5'b00000);
        tab[11] = mk(0, 0, 0, 0, 0,  0,1,0,1,0,  1,0,1,0,4,5'b00000);
        tab[12] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  0,0,0,1,4,5'b00000);
        tab[13] = mk(1,16, 8, 8, 0,  0,0,0,0,0,  0,0,0,1,4,5'b00000);
        tab[14] = mk(0, 0, 0, 0, 0,  0,0,0,0,1,  0,0,0,1,4,5'b10000);
        tab[15] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  0,0,0,1,4,5'b00000);
        tab[16] = mk(0, 0, 0, 0, 0,  1,0,0,0,0,  0,0,0,1,4,5'b00000);
        tab[17] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,0,0,1,4,5'b00000);
        tab[18] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,1,0,1,4,5'b00000);
        tab[19] = mk(0, 0, 0, 0, 0,  0,1,0,1,0,  1,0,0,1,4,5'b00000);
        tab[20] = mk(0, 0, 0, 0, 0,  0,0,0,0,1,  1,0,0,1,4,5'b01100);
        tab[21] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,0,0,1,4,5'b00000);
        tab[22] = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,1,4,5'b00000);
        tab[23] = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,1,4,5'b00000);
        tab[24] = mk(0, 0, 0, 0, 0,  0,1,0,0,0,  1,0,0,1,4,5'b00000);
        tab[25] = mk(0, 0, 0, 0, 0,  1,0,0,0,0,  1,0,0,1,4,5'b00000);
        tab[26] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,0,0,1,4,5'b00010);
        tab[27] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,1,0,1,4,5'b00010);
        tab[28] = mk(0, 0, 0, 0, 0,  0,0,0,0,1,  1,0,0,1,4,5'b00010);
        tab[29] = mk(0, 0, 0, 0, 0,  0,0,0,0,0,  1,0,0,1,4,5'b00000);

        // Reset
        resetn = 1'b0;
        enable = 1'b1;
        clr_in();
        set_cfg(0, 0, 0, 0);
        cfg_wr = 1'b0;
        repeat (3) @(posedge clk);
        settle();
        check("reset_state", dut_all(), 64'd0);
        resetn = 1'b1;

        // Directed per-cycle vectors
        for (int i = 0; i < 30; i++) begin
            next_cycle();
            if (tab[i].wr) set_cfg(tab[i].sw, tab[i].sh, tab[i].mw, tab[i].mh);
            src_fsync  = tab[i].fs;
            mon_tvalid = tab[i].tv;
            mon_tready = tab[i].tv;
            mon_tuser  = tab[i].tu;
            mon_tlast  = tab[i].tl;
            err_clr    = tab[i].clr;
            settle();
            check($sformatf("vec%0d", i), dut_tab(),
                  64'({tab[i].eb, tab[i].ef, tab[i].ed, FW'(tab[i].ec), RW'(tab[i].emw), tab[i].ee}));
        end

        // Stall timeout: RUN began at vector 28 with no beats since
        early = 0;
        for (int i = 30; i < 43; i++) begin
            next_cycle();
            settle();
            if (fsync || err_tmo || !busy) early++;
        end
        check("tmo_early", 64'(early), 64'd0);
        next_cycle();
        settle();
        check("tmo_edge", 64'({busy, fsync, err_tmo}), 64'(3'b100));
        next_cycle();
        settle();
        check("tmo_sync", 64'({busy, fsync, err_tmo, m_width}), 64'({3'b111, RW'(4)}));
        next_cycle();
        settle();
        check("tmo_run", 64'({busy, fsync}), 64'(2'b10));

        // Config write during RUN only touches the shadow
        next_cycle();
        set_cfg(16, 8, 8, 4);
        settle();
        donecnt = 0;
        mwbad   = 0;
        for (int b = 0; b < 8; b++) begin
            next_cycle();
            beat(b == 0, (b % 4) == 3);
            settle();
            if (m_width != RW'(4)) mwbad++;
            if (b < 7 && frame_done) donecnt++;
            if (b == 7) check("mid_done", 64'({frame_done, frame_cnt}), 64'({1'b1, FW'(1)}));
        end
        check("mid_mw_early_done", 64'({mwbad, donecnt}), 64'd0);
        next_cycle();
        src_fsync = 1'b1;
        settle();
        check("mid_idle", 64'({busy, frame_cnt, m_width}), 64'({1'b0, FW'(2), RW'(4)}));
        next_cycle();
        settle();
        check("mid_load", 64'({busy, fsync, s_width, s_height, m_width, m_height}),
              64'({2'b10, RW'(16), RW'(8), RW'(8), RW'(4)}));
        next_cycle();
        settle();
        check("mid_sync", 64'({busy, fsync}), 64'(2'b11));

        // Asynchronous reset in the middle of a frame
        next_cycle();
        beat(1'b1, 1'b0);
        settle();
        next_cycle();
        beat(1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", dut_all(), 64'd0);
        clr_in();
        settle();
        check("reset_hold", dut_all(), 64'd0);
        resetn = 1'b1;

        // Randomized run against the behavioural model
        model_reset();
        stall_left = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            enable    = ($urandom_range(0, 9) != 0);
            src_fsync = ($urandom_range(0, 39) == 0);
            err_clr   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) begin
                set_cfg($urandom_range(1, 1023), $urandom_range(1, 1023),
                        $urandom_range(1, 4), $urandom_range(1, 3));
                if ($urandom_range(0, 4) == 0) begin
                    case ($urandom_range(0, 3))
                        0: cfg_s_width  = '0;
                        1: cfg_s_height = '0;
                        2: cfg_m_width  = '0;
                        default: cfg_m_height = '0;
                    endcase
                end
            end
            if (stall_left > 0) begin
                stall_left--;
                mon_tvalid = 1'b0;
            end else begin
                if ($urandom_range(0, 199) == 0) stall_left = 20;
                mon_tvalid = ($urandom_range(0, 9) < 7);
            end
            mon_tready = ($urandom_range(0, 9) < 8);
            mon_tuser  = (!md_seen) ^ ($urandom_range(0, 19) == 0);
            mon_tlast  = (md_bil == md_act[2] - 1) ^ ($urandom_range(0, 24) == 0);
            settle();
            check($sformatf("rand%0d", c), dut_all(), model_expect());
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
